fifo_rr_sched: RTL and testbench
================================

// Module: fifo_rr_sched
// PURPOSE
//  Round-robin read scheduler draining NCH fifo_sync instances into one shared
//  valid/ready stream. Grants one channel at a time for a burst of up to BURST
//  words, drives that FIFO's rd_req, and forwards its head word with the channel
//  index. Sits between per-source sync FIFOs and a single downstream consumer.
// PARAMETERS
//  NCH         4   number of FIFO channels (>=2)
//  CH_W        2   channel index width, >= clog2(NCH)
//  DATA_WIDTH  8   FIFO word width
//  BURST       4   max words per grant (>=1)
//  BCNT_W      3   burst counter width, >= clog2(BURST+1)
// PORTS
//  clk         in   1              clock
//  rstn        in   1              asynchronous reset, active low
//  en          in   1              scheduler enable
//  ch_mask     in   NCH            1 = channel eligible for a new grant
//  ch_empty    in   NCH            per-channel FIFO rd_empty
//  ch_q        in   NCH*DATA_WIDTH per-channel FIFO head q; ch i at [i*DW +: DW]
//  ch_rd_req   out  NCH            per-channel FIFO rd_req (one-hot or zero)
//  out_valid   out  1              output word valid
//  out_ready   in   1              downstream accepts word
//  out_data    out  DATA_WIDTH     output word
//  out_ch      out  CH_W           source channel of out_data
//  out_last    out  1              word is last of current grant
//  busy        out  1              1 while in XFER
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, ptr=0, cnt=0; all outputs 0.
//  FSM states: IDLE, XFER. Registered: state, gnt, ptr, cnt.
//  IDLE: elig = ~ch_empty & ch_mask. If en && |elig:
//    gnt <= first set bit of elig, searching ptr, ptr+1, ... (mod NCH);
//    cnt <= 0; -> XFER. Otherwise stay. One cycle arbitration latency.
//  XFER, combinational outputs:
//    out_valid = !ch_empty[gnt]
//    out_data  = ch_q[gnt]
//    out_ch    = gnt
//    out_last  = out_valid && (cnt==BURST-1 || !en)
//    pop       = out_valid && out_ready
//    ch_rd_req = pop ? (1<<gnt) : 0
//  XFER, on each pop: cnt <= cnt+1.
//  XFER exits to IDLE with ptr <= (gnt+1) mod NCH when any of:
//    (a) pop && out_last (burst done, or en low);
//    (b) !out_valid (granted FIFO drained before BURST words).
//  Handshake: out_valid, once high, stays high with out_data/out_ch stable
//   until pop. Holds because the block is the only reader of each FIFO.
//   Downstream must not depend on out_valid to raise out_ready.
//  ch_mask / en changes mid-burst do not revoke the grant:
//   mask is sampled only in IDLE; en low ends the burst after the current word.
//  IDLE always costs one bubble cycle between grants.
//   Peak throughput: BURST words per BURST+1 cycles.
//  ptr wraps NCH-1 -> 0. With one eligible channel it is re-granted every burst.
//  Never pops an empty FIFO. ch_rd_req is never asserted in IDLE.
//  Async rstn mid-burst: immediate return to reset values. An in-flight word is
//   not popped and remains at the FIFO head.
// TESTING
//  T1: rstn low, ch_empty=4'hF -> all outputs 0, busy=0; after release stays IDLE.
//  T2: ch0 holds 6 words, en=1, ready=1 -> 4 words out_ch=0 (4th out_last=1),
//      1 idle cycle, then 2 words from ch0, exit via drain.
//  T3: ch0..ch3 each hold 4 words, ready=1 -> grant order 0,1,2,3,
//      each 4 words, one bubble between bursts.
//  T4: out_ready toggles 1/0 during burst -> out_data stable while valid&!ready;
//      exactly one ch_rd_req pulse per accepted word; no loss or duplication.
//  T5: en dropped mid-burst after 2nd word -> 3rd word completes with out_last=1,
//      FSM returns to IDLE and issues no new grant while en=0.
//  T6: ch_mask=4'b0100 with all FIFOs non-empty -> only ch2 granted;
//      rstn pulse mid-burst leaves ch2 FIFO count unchanged for the un-popped word.

Source files
------------

// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler: drains NCH sync FIFOs into one valid/ready stream,
// granting one channel at a time for a burst of up to BURST words.
module fifo_rr_sched #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST      = 4,
  parameter int unsigned BCNT_W     = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic [NCH-1:0]            ch_mask,
  input  logic [NCH-1:0]            ch_empty,
  input  logic [NCH*DATA_WIDTH-1:0] ch_q,
  output logic [NCH-1:0]            ch_rd_req,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [BCNT_W-1:0]   cnt_q, cnt_d;

  logic [NCH-1:0]        elig;
  logic                  found;
  logic [CH_W-1:0]       pick;
  logic [CH_W-1:0]       idx;
  logic [CH_W-1:0]       ptr_next;
  logic [DATA_WIDTH-1:0] head;
  logic                  gnt_empty;
  logic                  pop;

  assign elig      = ~ch_empty & ch_mask;
  assign head      = ch_q[32'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_empty = ch_empty[gnt_q];
  assign ptr_next  = (gnt_q == CH_W'(NCH-1)) ? '0 : gnt_q + CH_W'(1);

  // First eligible channel searching upward from ptr, wrapping at NCH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = CH_W'((32'(ptr_q) + k) % NCH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_ch    = '0;
    out_last  = 1'b0;
    ch_rd_req = '0;
    busy      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        out_valid = !gnt_empty;
        out_data  = head;
        out_ch    = gnt_q;
        out_last  = out_valid && ((cnt_q == BCNT_W'(BURST-1)) || !en);
        pop       = out_valid && out_ready;
        if (pop) begin
          ch_rd_req = NCH'(1) << gnt_q;
          cnt_d     = cnt_q + BCNT_W'(1);
        end
        // Leave on the last accepted word, or as soon as the granted FIFO runs dry.
        if ((pop && out_last) || !out_valid) begin
          state_d = IDLE;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Scoreboard bench for fifo_rr_sched: behavioural per-channel FIFOs, directed
// bursts with hand-computed expected words, and a negedge monitor that checks them.
module tb_fifo_rr_sched;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en;
  logic [3:0]  ch_mask;
  logic [3:0]  ch_empty;
  logic [31:0] ch_q;
  logic [3:0]  ch_rd_req;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        busy;

  fifo_rr_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .ch_mask   (ch_mask),
    .ch_empty  (ch_empty),
    .ch_q      (ch_q),
    .ch_rd_req (ch_rd_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stimulus-owned state
  logic [7:0] mem [4][32];
  int         wp [4];
  int         rp [4];
  int         pops [4];
  exp_t       exp_q [$];
  bit         idle_chk;
  int         tmo_n;

  // Monitor-owned state
  int         checks;
  int         fails;
  int         mon_idx;
  bit         hold;
  bit         last_hs;
  bit         hs;
  logic [7:0] hold_d;
  logic [1:0] hold_ch;
  exp_t       e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    checks = 0; fails = 0; mon_idx = 0; hold = 1'b0; last_hs = 1'b0; hs = 1'b0;
    hold_d = '0; hold_ch = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("reset_outputs", 32'({out_valid, out_last, busy, ch_rd_req, out_data, out_ch}), 32'd0);
        hold    = 1'b0;
        last_hs = 1'b0;
      end else begin
        hs = out_valid && out_ready;
        chk("rd_req", 32'(ch_rd_req), hs ? (32'd1 << out_ch) : 32'd0);
        if (hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(hold_d));
          chk("hold_ch", 32'(out_ch), 32'(hold_ch));
        end
        if (last_hs) chk("bubble_busy", 32'(busy), 32'd0);
        if (idle_chk) chk("idle_busy", 32'(busy), 32'd0);
        if (hs) begin
          if (mon_idx < exp_q.size()) begin
            e = exp_q[mon_idx];
            chk("word_data", 32'(out_data), 32'(e.d));
            chk("word_ch", 32'(out_ch), 32'(e.ch));
            chk("word_last", 32'(out_last), 32'(e.last));
            mon_idx++;
          end else begin
            checks++;
            fails++;
            $display("FAIL extra_word: got data 0x%0h ch %0d, required no word at %0t",
                     out_data, out_ch, $time);
          end
        end
        hold    = out_valid && !out_ready;
        hold_d  = out_data;
        hold_ch = out_ch;
        last_hs = hs && out_last;
      end
      chk("timeout", 32'(tmo_n), 32'd0);
    end
  end

  task automatic refresh();
    for (int c = 0; c < 4; c++) begin
      ch_empty[c]    = (wp[c] == rp[c]);
      ch_q[c*8 +: 8] = (wp[c] == rp[c]) ? 8'h00 : mem[c][rp[c]];
    end
  endtask

  // One clock: sample rd_req at negedge, pop the model FIFOs just after posedge.
  task automatic tick();
    logic [3:0] rd;
    @(negedge clk);
    rd = ch_rd_req;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (rd[c] && (rp[c] < wp[c])) begin
        rp[c]++;
        pops[c]++;
      end
    end
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int c, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][wp[c]] = base + 8'(k);
      wp[c]++;
    end
    refresh();
  endtask

  task automatic exp_burst(input int c, input logic [7:0] base, input int n, input bit last_end);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      x.d    = base + 8'(k);
      x.ch   = 2'(c);
      x.last = last_end && (k == n - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while ((mon_idx < exp_q.size()) && (i < bound)) begin
      tick();
      i++;
    end
    if (mon_idx < exp_q.size()) tmo_n++;
    ticks(3);
  endtask

  task automatic wait_pops(input int c, input int target, input int bound);
    int i;
    i = 0;
    while ((pops[c] < target) && (i < bound)) begin
      tick();
      i++;
    end
    if (pops[c] < target) tmo_n++;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    ticks(2);
    rstn = 1'b1;
  endtask

  initial begin
    int p;
    en = 1'b1; ch_mask = 4'hF; out_ready = 1'b1; idle_chk = 1'b0; tmo_n = 0;
    for (int c = 0; c < 4; c++) begin
      wp[c] = 0; rp[c] = 0; pops[c] = 0;
    end
    refresh();
    #2 rstn = 1'b0;

    // T1: reset with all FIFOs empty, then stays idle
    ticks(3);
    rstn = 1'b1;
    idle_chk = 1'b1;
    ticks(4);
    idle_chk = 1'b0;

    // T2: six words on ch0 -> full burst, bubble, drain burst of two
    load(0, 8'h10, 6);
    exp_burst(0, 8'h10, 4, 1'b1);
    exp_burst(0, 8'h14, 2, 1'b0);
    wait_done(60);

    // T3: four words on every channel -> grants 0,1,2,3
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      load(c, 8'h40 + 8'(c * 16), 4);
      exp_burst(c, 8'h40 + 8'(c * 16), 4, 1'b1);
    end
    wait_done(100);

    // T4: out_ready toggling during a ch2 burst
    reset_dut();
    out_ready = 1'b0;
    p = pops[2];
    load(2, 8'h80, 4);
    exp_burst(2, 8'h80, 4, 1'b1);
    for (int i = 0; (i < 40) && (pops[2] < p + 4); i++) begin
      out_ready = ~out_ready;
      tick();
    end
    if (pops[2] < p + 4) tmo_n++;
    out_ready = 1'b1;
    wait_done(20);

    // T5: en dropped after the 2nd word ends the burst on the 3rd
    en = 1'b0;
    reset_dut();
    load(1, 8'hA0, 5);
    exp_burst(1, 8'hA0, 3, 1'b1);
    idle_chk = 1'b1;
    ticks(3);
    idle_chk = 1'b0;
    en = 1'b1;
    p = pops[1];
    wait_pops(1, p + 2, 20);
    en = 1'b0;
    tick();
    idle_chk = 1'b1;
    ticks(4);
    idle_chk = 1'b0;
    exp_burst(1, 8'hA3, 2, 1'b0);
    en = 1'b1;
    wait_done(40);

    // T6: only ch2 eligible; reset mid-burst keeps the un-popped word
    ch_mask = 4'b0100;
    reset_dut();
    load(0, 8'hC0, 2);
    load(1, 8'hD0, 2);
    load(3, 8'hF0, 2);
    p = pops[2];
    load(2, 8'hE0, 6);
    exp_burst(2, 8'hE0, 4, 1'b1);
    exp_burst(2, 8'hE4, 1, 1'b0);
    exp_burst(2, 8'hE5, 1, 1'b0);
    wait_pops(2, p + 5, 40);
    rstn = 1'b0;
    ticks(2);
    rstn = 1'b1;
    wait_pops(2, p + 6, 40);
    ticks(3);
    // ptr now points at ch3: remaining channels drain 3, 0, 1
    exp_burst(3, 8'hF0, 2, 1'b0);
    exp_burst(0, 8'hC0, 2, 1'b0);
    exp_burst(1, 8'hD0, 2, 1'b0);
    ch_mask = 4'hF;
    wait_done(100);

    ticks(2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
